// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt controller.
//   irq_state_e : dispatch FSM states (IDLE, SERVICE, HOLDOFF)
//   SRC_KEY/ETH : bit positions of each source in pending/src_id vectors
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

  localparam int SRC_KEY = 0;
  localparam int SRC_ETH = 1;
  localparam int NUM_SRC = 2;

endpackage

// File: rtl/irq_debounce.sv
// irq_debounce: two-flop synchroniser followed by a stability counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous input (push-key)
//   level      : debounced level; follows raw only after 2^DB_BITS
//                consecutive synchronised samples disagree with it
module irq_debounce #(
  parameter int DB_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic [1:0]         sync_q;
  logic [DB_BITS-1:0] cnt;

  // Metastability guard: raw is sampled twice before anything looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Any sample equal to the current level restarts the count, so only an
  // unbroken run of differing samples can flip the output. The flip happens
  // on the sample that would overflow the counter, i.e. the 2^DB_BITS-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_q[1] == level) begin
      cnt <= '0;
    end else if (&cnt) begin
      cnt   <= '0;
      level <= sync_q[1];
    end else begin
      cnt <= cnt + DB_BITS'(1);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: collects key and Ethernet interrupts, arbitrates
// round-robin, issues one interrupt pulse per handler invocation.
//   clk, rst_n        : clock, asynchronous active-low reset
//   key_raw           : raw push-key (debounced internally)
//   eth_irq, eth_data : Ethernet event strobe and its payload
//   key_en, eth_en    : per-source dispatch enables
//   pipe_busy         : pipeline cannot accept an interrupt this cycle
//   rti, rsi          : handler return / handler abort strobes
//   interrupt         : one-cycle dispatch pulse
//   src_data, src_id  : RDI data and one-hot id of the granted source
//   in_service        : handler active
//   pending, eth_ovf  : pending flags, sticky Ethernet overflow
module irq_controller
  import irq_pkg::*;
#(
  parameter int          DB_BITS  = 16,
  parameter logic [31:0] KEY_CODE = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_raw,
  input  logic                 eth_irq,
  input  logic [31:0]          eth_data,
  input  logic                 key_en,
  input  logic                 eth_en,
  input  logic                 pipe_busy,
  input  logic                 rti,
  input  logic                 rsi,
  output logic                 interrupt,
  output logic [31:0]          src_data,
  output logic [NUM_SRC-1:0]   src_id,
  output logic                 in_service,
  output logic [NUM_SRC-1:0]   pending,
  output logic                 eth_ovf
);

  logic               key_level;
  logic               key_level_q;
  logic               key_rise;
  logic [31:0]        eth_buf;
  irq_state_e         state;
  logic               last_grant_eth;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic               grant;
  logic               grant_eth;
  logic               rsi_eff;

  irq_debounce #(.DB_BITS(DB_BITS)) u_key_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (key_raw),
    .level (key_level)
  );

  // Edge detector on the debounced key: only a press raises an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_level_q <= 1'b0;
    end else begin
      key_level_q <= key_level;
    end
  end

  assign key_rise = key_level & ~key_level_q;

  // Grant decision and pending set/clear vectors. On a tie the source that
  // did not win last time is chosen. Aborts are only honoured in SERVICE.
  always_comb begin
    eligible  = pending & {eth_en, key_en};
    grant     = (state == IDLE) && (|eligible) && !pipe_busy;
    grant_eth = (&eligible) ? ~last_grant_eth : eligible[SRC_ETH];
    rsi_eff   = (state == SERVICE) && rsi;
    set_vec   = '0;
    set_vec[SRC_KEY] = key_rise;
    set_vec[SRC_ETH] = eth_irq;
    clr_vec   = {NUM_SRC{rsi_eff}};
    clr_vec[SRC_ETH] = clr_vec[SRC_ETH] | (grant & grant_eth);
    clr_vec[SRC_KEY] = clr_vec[SRC_KEY] | (grant & ~grant_eth);
  end

  // Pending flags, Ethernet payload buffer and overflow. A new event in the
  // same cycle as a clear wins, so no event is ever dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      eth_buf <= '0;
      eth_ovf <= 1'b0;
    end else begin
      pending <= set_vec | (pending & ~clr_vec);
      if (eth_irq) begin
        eth_buf <= eth_data;
      end
      if (eth_irq && pending[SRC_ETH]) begin
        eth_ovf <= 1'b1;
      end else if (rsi_eff) begin
        eth_ovf <= 1'b0;
      end
    end
  end

  // Dispatch FSM with registered outputs. HOLDOFF gives the pipeline one
  // quiet cycle after the handler returns before the next dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      interrupt      <= 1'b0;
      src_data       <= '0;
      src_id         <= '0;
      in_service     <= 1'b0;
      last_grant_eth <= 1'b0;
    end else begin
      interrupt <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            interrupt      <= 1'b1;
            in_service     <= 1'b1;
            last_grant_eth <= grant_eth;
            src_id         <= grant_eth ? 2'b10 : 2'b01;
            src_data       <= grant_eth ? eth_buf : KEY_CODE;
            state          <= SERVICE;
          end
        end
        SERVICE: begin
          if (rti || rsi) begin
            in_service <= 1'b0;
            state      <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scoreboard bench for irq_controller.
// Stimulus pushes the expected grant (id, data, cycle) into a queue; a
// monitor pops one entry per interrupt pulse and compares.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_raw, eth_irq, key_en, eth_en, pipe_busy, rti, rsi;
  logic [31:0] eth_data;
  logic        interrupt, in_service, eth_ovf;
  logic [31:0] src_data;
  logic [1:0]  src_id, pending;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  irq_controller #(.DB_BITS(2), .KEY_CODE(32'hFFFF_FFFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .eth_irq    (eth_irq),
    .eth_data   (eth_data),
    .key_en     (key_en),
    .eth_en     (eth_en),
    .pipe_busy  (pipe_busy),
    .rti        (rti),
    .rsi        (rsi),
    .interrupt  (interrupt),
    .src_data   (src_data),
    .src_id     (src_id),
    .in_service (in_service),
    .pending    (pending),
    .eth_ovf    (eth_ovf)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected interrupt pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Inputs change and are inspected 1 time unit after the falling edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_grant(input logic [1:0] id, input logic [31:0] data, input int at_cyc);
    exp_t e;
    e.id = id;
    e.data = data;
    e.cyc = at_cyc;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [31:0] data);
    eth_data = data;
    eth_irq  = 1'b1;
    tick();
    eth_irq  = 1'b0;
  endtask

  task automatic pulse_rti();
    rti = 1'b1;
    tick();
    rti = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    check_output("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Monitor: every interrupt pulse must match the oldest expected grant.
  always @(negedge clk) begin
    if (rst_n && interrupt) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_irq: got src_id=%b src_data=%h, required no interrupt", src_id, src_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("irq_src_id", 32'(src_id), 32'(e.id));
        check_output("irq_src_data", src_data, e.data);
        check_output("irq_in_service", 32'(in_service), 32'd1);
        if (e.cyc >= 0) check_output("irq_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    rst_n = 1'b0; key_raw = 0; eth_irq = 0; eth_data = '0; key_en = 0;
    eth_en = 0; pipe_busy = 0; rti = 0; rsi = 0;
    tick(2);
    check_output("rst_interrupt", 32'(interrupt), 32'd0);
    check_output("rst_src_data", src_data, 32'd0);
    check_output("rst_src_id", 32'(src_id), 32'd0);
    check_output("rst_in_service", 32'(in_service), 32'd0);
    check_output("rst_pending", 32'(pending), 32'd0);
    check_output("rst_eth_ovf", 32'(eth_ovf), 32'd0);
    rst_n = 1'b1;
    key_en = 1; eth_en = 1;
    tick();

    // Bouncing key press: one interrupt only.
    expect_grant(2'b01, 32'hFFFF_FFFF, -1);
    key_raw = 1; tick(); key_raw = 0; tick(); key_raw = 1; tick(10);
    wait_drain(20);
    check_output("key_in_service", 32'(in_service), 32'd1);
    pulse_rti();
    check_output("key_rti_in_service", 32'(in_service), 32'd0);
    key_raw = 0;
    tick(10);
    check_output("key_pending_clear", 32'(pending), 32'd0);

    // Single Ethernet event, two-cycle latency.
    expect_grant(2'b10, 32'h0000_00A5, cyc + 2);
    apply_stimulus(32'h0000_00A5);
    check_output("eth_pending_set", 32'(pending), 32'b10);
    tick();
    check_output("eth_pending_cleared", 32'(pending), 32'b00);
    pulse_rti();
    tick(3);

    // Tie from reset: eth first, key two cycles after rti.
    do_reset();
    key_en = 0; eth_en = 0;
    key_raw = 1; tick(10);
    apply_stimulus(32'h5A5A_0001);
    check_output("tie_pending", 32'(pending), 32'b11);
    expect_grant(2'b10, 32'h5A5A_0001, cyc + 1);
    key_en = 1; eth_en = 1;
    tick(3);
    c = cyc;
    expect_grant(2'b01, 32'hFFFF_FFFF, c + 3);
    pulse_rti();
    check_output("holdoff_in_service", 32'(in_service), 32'd0);
    wait_drain(10);
    pulse_rti();
    key_raw = 0;
    tick(10);

    // Overflow while pipeline busy: latest payload, single interrupt.
    pipe_busy = 1;
    apply_stimulus(32'h0000_0011);
    apply_stimulus(32'h0000_0022);
    check_output("ovf_set", 32'(eth_ovf), 32'd1);
    check_output("ovf_pending", 32'(pending), 32'b10);
    tick(5);
    check_output("busy_hold_pending", 32'(pending), 32'b10);
    expect_grant(2'b10, 32'h0000_0022, cyc + 1);
    pipe_busy = 0;
    wait_drain(10);
    tick(5);
    check_output("ovf_pending_cleared", 32'(pending), 32'b00);
    pulse_rti();
    tick(3);

    // rsi discards a pending key and the overflow flag.
    expect_grant(2'b10, 32'h0000_0033, cyc + 2);
    apply_stimulus(32'h0000_0033);
    wait_drain(10);
    key_raw = 1; tick(10);
    check_output("rsi_pre_pending", 32'(pending), 32'b01);
    check_output("rsi_pre_ovf", 32'(eth_ovf), 32'd1);
    rsi = 1; tick(); rsi = 0;
    check_output("rsi_pending", 32'(pending), 32'b00);
    check_output("rsi_ovf", 32'(eth_ovf), 32'd0);
    tick(5);

    // Event coinciding with rsi survives.
    expect_grant(2'b10, 32'h0000_0055, cyc + 2);
    apply_stimulus(32'h0000_0055);
    wait_drain(10);
    eth_en = 0;
    rsi = 1; eth_irq = 1; eth_data = 32'h0000_0066;
    tick();
    rsi = 0; eth_irq = 0;
    check_output("rsi_set_wins", 32'(pending), 32'b10);
    tick(4);
    check_output("rsi_set_kept", 32'(pending), 32'b10);
    expect_grant(2'b10, 32'h0000_0066, cyc + 1);
    eth_en = 1;
    wait_drain(10);
    pulse_rti();
    key_raw = 0;
    tick(8);

    // Asynchronous reset in the middle of service.
    expect_grant(2'b10, 32'h0000_0077, cyc + 2);
    apply_stimulus(32'h0000_0077);
    wait_drain(10);
    rst_n = 0;
    #1;
    check_output("arst_interrupt", 32'(interrupt), 32'd0);
    check_output("arst_src_data", src_data, 32'd0);
    check_output("arst_src_id", 32'(src_id), 32'd0);
    check_output("arst_in_service", 32'(in_service), 32'd0);
    check_output("arst_pending", 32'(pending), 32'd0);
    tick(2);
    rst_n = 1;
    tick();
    expect_grant(2'b10, 32'h0000_0088, cyc + 2);
    apply_stimulus(32'h0000_0088);
    wait_drain(10);
    pulse_rti();
    tick(3);

    check_output("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
